// File: rtl/multi_port_ring_fifo_pkg.sv
// Shared helpers for the multi-port ring FIFO: pointer/count widths, lane popcount, thermometer check.
// Lane vectors are zero-extended to MaxLanes before being passed to these functions.
package multi_port_ring_fifo_pkg;

  localparam int MaxLanes = 32;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

  function automatic logic [7:0] popcount(input logic [MaxLanes-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MaxLanes; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

  // Lane 0 first, no gaps: adding one to the low run of ones clears it completely.
  function automatic logic is_thermo(input logic [MaxLanes-1:0] v);
    return ((v & (v + MaxLanes'(1))) == '0);
  endfunction

endpackage

// File: rtl/multi_port_ring_fifo_ring_ptr_adv.sv
// Modular pointer add for a ring of arbitrary Depth; combinational, no backpressure.
// Exact for non-power-of-2 Depth as long as inc_i <= Depth.
module ring_ptr_adv
  import multi_port_ring_fifo_pkg::*;
#(
  parameter  int Depth = 8,
  parameter  int IncW  = cnt_w(Depth),
  localparam int PtrW  = ptr_w(Depth)
) (
  input  logic [PtrW-1:0] ptr_i,
  input  logic [IncW-1:0] inc_i,
  output logic [PtrW-1:0] ptr_o
);

  localparam int SumW = ((PtrW > IncW) ? PtrW : IncW) + 1;

  logic [SumW-1:0] w_sum;

  assign w_sum = SumW'(ptr_i) + SumW'(inc_i);
  assign ptr_o = (w_sum >= SumW'(Depth)) ? PtrW'(w_sum - SumW'(Depth)) : PtrW'(w_sum);

endmodule

// File: rtl/multi_port_ring_fifo.sv
// Multi-lane in-order ring FIFO; 1-cycle latency, 0 when empty with MULTI_PORT_RING_FIFO_BYPASS_EN.
// Backpressure: lane ready from registered free space only; flush/rst drop all handshakes.
module multi_port_ring_fifo
  import multi_port_ring_fifo_pkg::*;
#(
  parameter int Depth       = 8,
  parameter int DataWidth   = 32,
  parameter int EnqWidth    = 2,
  parameter int DeqWidth    = 2,
  parameter int TakenAll    = 0,
  parameter int AFullThresh = Depth - EnqWidth,
  localparam int CntW       = cnt_w(Depth)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [EnqWidth-1:0]                 enq_vld_i,
  input  logic [EnqWidth-1:0][DataWidth-1:0]  enq_payload_i,
  output logic [EnqWidth-1:0]                 enq_rdy_o,
  output logic [DeqWidth-1:0]                 deq_vld_o,
  output logic [DeqWidth-1:0][DataWidth-1:0]  deq_payload_o,
  input  logic [DeqWidth-1:0]                 deq_rdy_i,
  output logic [CntW-1:0]                     count_o,
  output logic                                empty_o,
  output logic                                full_o,
  output logic                                almost_full_o
);

  localparam int PtrW = ptr_w(Depth);
  localparam int BypW = (EnqWidth < DeqWidth) ? EnqWidth : DeqWidth;

  logic [PtrW-1:0]      r_head;
  logic [PtrW-1:0]      r_tail;
  logic [CntW-1:0]      r_cnt;
  logic [DataWidth-1:0] r_mem [Depth];

  logic                 w_blk;
  logic                 w_byp;
  logic [CntW-1:0]      w_free;
  logic [EnqWidth-1:0]  w_enq_fire;
  logic [DeqWidth-1:0]  w_deq_fire;
  logic [EnqWidth-1:0]  w_wr_en;
  logic [CntW-1:0]      w_n_enq;
  logic [CntW-1:0]      w_n_deq;
  logic [CntW-1:0]      w_nbyp;
  logic [PtrW-1:0]      w_head_nxt;
  logic [PtrW-1:0]      w_tail_nxt;
  logic [PtrW-1:0]      w_wr_slot [EnqWidth];
  logic [PtrW-1:0]      w_rd_slot [DeqWidth];

  assign w_blk  = flush_i | rst;
  assign w_free = CntW'(Depth) - r_cnt;

`ifdef MULTI_PORT_RING_FIFO_BYPASS_EN
  assign w_byp = (r_cnt == '0) & ~flush_i;
`else
  assign w_byp = 1'b0;
`endif

  for (genvar i = 0; i < EnqWidth; i++) begin : g_enq
    assign enq_rdy_o[i] = ~w_blk & ((TakenAll != 0) ? (w_free >= CntW'(EnqWidth))
                                                     : (w_free > CntW'(i)));
    assign w_enq_fire[i] = enq_vld_i[i] & enq_rdy_o[i];
    // Lanes handed straight to the dequeue side are not stored; the rest pack down from r_tail.
    assign w_wr_en[i] = w_enq_fire[i] & (CntW'(i) >= w_nbyp);
    ring_ptr_adv #(.Depth(Depth), .IncW(CntW)) u_wr_slot (
      .ptr_i (r_tail),
      .inc_i (CntW'(i) - w_nbyp),
      .ptr_o (w_wr_slot[i])
    );
  end

  for (genvar i = 0; i < DeqWidth; i++) begin : g_deq
    ring_ptr_adv #(.Depth(Depth), .IncW(CntW)) u_rd_slot (
      .ptr_i (r_head),
      .inc_i (CntW'(i)),
      .ptr_o (w_rd_slot[i])
    );
    if (i < BypW) begin : g_byp
      assign deq_vld_o[i]     = w_byp ? w_enq_fire[i] : (~w_blk & (r_cnt > CntW'(i)));
      assign deq_payload_o[i] = w_byp ? enq_payload_i[i] : r_mem[w_rd_slot[i]];
    end else begin : g_reg
      assign deq_vld_o[i]     = ~w_blk & (r_cnt > CntW'(i));
      assign deq_payload_o[i] = r_mem[w_rd_slot[i]];
    end
    assign w_deq_fire[i] = deq_vld_o[i] & deq_rdy_i[i];
  end

  assign w_n_enq = CntW'(popcount(MaxLanes'(w_enq_fire)));
  assign w_n_deq = CntW'(popcount(MaxLanes'(w_deq_fire)));
  assign w_nbyp  = w_byp ? w_n_deq : '0;

  ring_ptr_adv #(.Depth(Depth), .IncW(CntW)) u_head_adv (
    .ptr_i (r_head),
    .inc_i (w_n_deq - w_nbyp),
    .ptr_o (w_head_nxt)
  );

  ring_ptr_adv #(.Depth(Depth), .IncW(CntW)) u_tail_adv (
    .ptr_i (r_tail),
    .inc_i (w_n_enq - w_nbyp),
    .ptr_o (w_tail_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
      r_cnt  <= r_cnt + w_n_enq - w_n_deq;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < EnqWidth; j++) begin
      if (w_wr_en[j]) begin
        r_mem[w_wr_slot[j]] <= enq_payload_i[j];
      end
    end
  end

  assign count_o       = r_cnt;
  assign empty_o       = (r_cnt == '0);
  assign full_o        = (r_cnt == CntW'(Depth));
  assign almost_full_o = (32'(r_cnt) >= AFullThresh);

  a_enq_vld_thermo: assert property (@(posedge clk) disable iff (rst)
    is_thermo(MaxLanes'(enq_vld_i)));
  a_deq_rdy_thermo: assert property (@(posedge clk) disable iff (rst)
    is_thermo(MaxLanes'(deq_rdy_i)));

endmodule

// File: tb/tb_multi_port_ring_fifo.sv
// Directed bench: Depth=8 and Depth=5 instances, 2 enq / 2 deq lanes, hand-computed expectations.
module tb_multi_port_ring_fifo;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  logic [1:0]       e8_vld, e8_rdy, d8_vld, d8_rdy;
  logic [1:0][31:0] e8_dat, d8_dat;
  logic [3:0]       c8;
  logic             empty8, full8, afull8;

  logic [1:0]       e5_vld, e5_rdy, d5_vld, d5_rdy;
  logic [1:0][31:0] e5_dat, d5_dat;
  logic [2:0]       c5;
  logic             empty5, full5, afull5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_port_ring_fifo #(.Depth(8)) u_dut8 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .enq_vld_i(e8_vld), .enq_payload_i(e8_dat), .enq_rdy_o(e8_rdy),
    .deq_vld_o(d8_vld), .deq_payload_o(d8_dat), .deq_rdy_i(d8_rdy),
    .count_o(c8), .empty_o(empty8), .full_o(full8), .almost_full_o(afull8)
  );

  multi_port_ring_fifo #(.Depth(5)) u_dut5 (
    .clk(clk), .rst(rst), .flush_i(1'b0),
    .enq_vld_i(e5_vld), .enq_payload_i(e5_dat), .enq_rdy_o(e5_rdy),
    .deq_vld_o(d5_vld), .deq_payload_o(d5_dat), .deq_rdy_i(d5_rdy),
    .count_o(c5), .empty_o(empty5), .full_o(full5), .almost_full_o(afull5)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks follow after a further settle delay.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq8(input logic [1:0] vld, input logic [31:0] l1, input logic [31:0] l0);
    e8_vld = vld;
    e8_dat[1] = l1;
    e8_dat[0] = l0;
    step();
    e8_vld = 2'b00;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    e8_vld = '0; e8_dat = '0; d8_rdy = '0;
    e5_vld = '0; e5_dat = '0; d5_rdy = '0;
    step(); step();
    chk("rst_enq_rdy", e8_rdy, 2'b00);
    chk("rst_deq_vld", d8_vld, 2'b00);
    rst = 1'b0;
    #1;
    chk("post_rst_count", c8, 4'd0);
    chk("post_rst_empty", empty8, 1'b1);
    chk("post_rst_full", full8, 1'b0);
    chk("post_rst_afull", afull8, 1'b0);
    chk("post_rst_enq_rdy", e8_rdy, 2'b11);

    enq8(2'b11, 32'hB0, 32'hA0);
    enq8(2'b11, 32'hD0, 32'hC0);
    #1;
    chk("four_count", c8, 4'd4);
    chk("four_deq_vld", d8_vld, 2'b11);
    chk("four_deq0", d8_dat[0], 32'hA0);
    chk("four_deq1", d8_dat[1], 32'hB0);
    chk("four_afull", afull8, 1'b0);

    enq8(2'b11, 32'h12, 32'h11);
    enq8(2'b01, 32'h0, 32'h13);
    #1;
    chk("seven_count", c8, 4'd7);
    chk("seven_enq_rdy", e8_rdy, 2'b01);
    chk("seven_afull", afull8, 1'b1);
    chk("seven_full", full8, 1'b0);
    enq8(2'b01, 32'h0, 32'hE0);
    #1;
    chk("full_full", full8, 1'b1);
    chk("full_enq_rdy", e8_rdy, 2'b00);
    chk("full_count", c8, 4'd8);

    // Full: dequeue frees space only for the following cycle.
    d8_rdy = 2'b11; e8_vld = 2'b11; e8_dat[1] = 32'hF1; e8_dat[0] = 32'hF0;
    #1;
    chk("full_both_enq_rdy", e8_rdy, 2'b00);
    step();
    e8_vld = 2'b00; d8_rdy = 2'b00;
    #1;
    chk("after_full_count", c8, 4'd6);
    chk("after_full_enq_rdy", e8_rdy, 2'b11);
    chk("after_full_deq0", d8_dat[0], 32'hC0);
    chk("after_full_deq1", d8_dat[1], 32'hD0);

    d8_rdy = 2'b11;
    step(); #1;
    chk("drain1_deq0", d8_dat[0], 32'h11);
    chk("drain1_deq1", d8_dat[1], 32'h12);
    step(); #1;
    chk("drain2_deq0", d8_dat[0], 32'h13);
    chk("drain2_deq1", d8_dat[1], 32'hE0);
    step(); #1;
    d8_rdy = 2'b00;
    chk("drained_count", c8, 4'd0);
    chk("drained_empty", empty8, 1'b1);

    enq8(2'b11, 32'h21, 32'h20);
    enq8(2'b01, 32'h0, 32'h22);
    #1;
    chk("pre_flush_count", c8, 4'd3);
    flush = 1'b1; e8_vld = 2'b11;
    #1;
    chk("flush_enq_rdy", e8_rdy, 2'b00);
    chk("flush_deq_vld", d8_vld, 2'b00);
    step();
    flush = 1'b0; e8_vld = 2'b00;
    #1;
    chk("flush_count", c8, 4'd0);
    chk("flush_empty", empty8, 1'b1);

    enq8(2'b11, 32'h31, 32'h30);
    enq8(2'b01, 32'h0, 32'h32);
    #1;
    chk("pre_rst_count", c8, 4'd3);
    rst = 1'b1; e8_vld = 2'b11;
    #1;
    chk("midrst_enq_rdy", e8_rdy, 2'b00);
    chk("midrst_deq_vld", d8_vld, 2'b00);
    step();
    rst = 1'b0; e8_vld = 2'b00;
    #1;
    chk("midrst_count", c8, 4'd0);
    chk("midrst_empty", empty8, 1'b1);
    chk("d5_rst_count", c5, 3'd0);

    enq8(2'b01, 32'h0, 32'h40);
    #1;
    chk("refill_count", c8, 4'd1);
    chk("refill_deq0", d8_dat[0], 32'h40);
    chk("refill_deq_vld", d8_vld, 2'b01);
    d8_rdy = 2'b11;
    step(); #1;
    d8_rdy = 2'b00;
    chk("refill_drained", c8, 4'd0);

`ifdef MULTI_PORT_RING_FIFO_BYPASS_EN
    e8_vld = 2'b11; e8_dat[1] = 32'h59; e8_dat[0] = 32'h58; d8_rdy = 2'b01;
    #1;
    chk("byp_deq_vld0", d8_vld[0], 1'b1);
    chk("byp_deq0", d8_dat[0], 32'h58);
    step();
    e8_vld = 2'b00; d8_rdy = 2'b00;
    #1;
    chk("byp_count", c8, 4'd1);
    chk("byp_next_deq0", d8_dat[0], 32'h59);
    d8_rdy = 2'b01;
    step(); #1;
    d8_rdy = 2'b00;
    chk("byp_drained", c8, 4'd0);
`endif

    // Depth=5: prime two entries, then stream 2-in/2-out across many wraps.
    e5_vld = 2'b11; e5_dat[1] = 32'h501; e5_dat[0] = 32'h500;
    step();
    for (int c = 0; c < 20; c++) begin
      e5_vld = 2'b11;
      e5_dat[0] = 32'h500 + 32'(2 * c + 2);
      e5_dat[1] = 32'h500 + 32'(2 * c + 3);
      d5_rdy = 2'b11;
      #1;
      chk("d5_count", c5, 3'd2);
      chk("d5_deq_vld", d5_vld, 2'b11);
      chk("d5_deq0", d5_dat[0], 32'h500 + 32'(2 * c));
      chk("d5_deq1", d5_dat[1], 32'h500 + 32'(2 * c + 1));
      step();
    end
    e5_vld = 2'b00; d5_rdy = 2'b00;
    #1;
    chk("d5_final_count", c5, 3'd2);
    chk("d5_final_deq0", d5_dat[0], 32'h500 + 32'd40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
